// File: rtl/lut_neuron_pkg.sv
// Shared constants, FSM state type and depth helper for the programmable LUT neuron.
package lut_neuron_pkg;

    localparam int LNP_IN_BITS  = 6;
    localparam int LNP_OUT_BITS = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic int lnp_depth(input int in_bits);
        return 1 << in_bits;
    endfunction

endpackage

// File: rtl/lut_neuron_table_ram.sv
// Distributed-RAM truth table: one synchronous write port, one asynchronous read port.
// Reads see the pre-write contents in the cycle of a write to the same address.
module lut_neuron_table_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 2,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdat,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdat
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/lut_neuron_prog.sv
// Runtime-programmable truth-table neuron; 1-cycle lookup latency, valid/ready on both sides.
// Output holds under out_ready=0; the table is swept to zero after reset or on clr_req.
module lut_neuron_prog
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = LNP_IN_BITS,
    parameter int OUT_BITS = LNP_OUT_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_req,
    output logic                busy,
    input  logic                cfg_we,
    input  logic [IN_BITS-1:0]  cfg_addr,
    input  logic [OUT_BITS-1:0] cfg_data,
    output logic                cfg_err,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data
);

    localparam int DEPTH = lnp_depth(IN_BITS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IN_BITS-1:0]  r_ptr;
    logic [IN_BITS-1:0]  w_ptr_nxt;
    logic                r_out_vld;
    logic [OUT_BITS-1:0] r_out_dat;
    logic                r_cfg_err;

    logic                w_run;
    logic                w_in_acc;
    logic                w_ram_we;
    logic [IN_BITS-1:0]  w_ram_addr;
    logic [OUT_BITS-1:0] w_ram_wdat;
    logic [OUT_BITS-1:0] w_ram_rdat;

    assign w_run    = (r_state == ST_RUN);
    assign busy     = !w_run;
    assign in_ready = w_run && !clr_req && (!r_out_vld || out_ready);
    assign w_in_acc = in_valid && in_ready;

    // The sweep owns the write port in CLEAR; config writes only reach the table in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ram_we    = 1'b0;
        w_ram_addr  = cfg_addr;
        w_ram_wdat  = cfg_data;
        case (r_state)
            ST_CLEAR: begin
                w_ram_we   = 1'b1;
                w_ram_addr = r_ptr;
                w_ram_wdat = '0;
                w_ptr_nxt  = r_ptr + IN_BITS'(1);
                if (&r_ptr) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ram_we = cfg_we;
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_run;
            if (w_in_acc) begin
                r_out_vld <= 1'b1;
                r_out_dat <= w_ram_rdat;
            end else if (out_ready) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    lut_neuron_table_ram #(
        .ADDR_W (IN_BITS),
        .DATA_W (OUT_BITS),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_addr),
        .i_wdat  (w_ram_wdat),
        .i_raddr (in_data),
        .o_rdat  (w_ram_rdat)
    );

    assign out_valid = r_out_vld;
    assign out_data  = r_out_dat;
    assign cfg_err   = r_cfg_err;

endmodule

// File: doc/lut_neuron_prog.md
Name: lut_neuron_prog

Overview:
- Runtime-programmable, pipelined truth-table neuron; the parametrised successor to the fixed combinational per-neuron ROMs.
- Holds a 2^IN_BITS x OUT_BITS table in distributed RAM and performs one lookup per accepted input, with a valid/ready handshake on both sides.
- The table is cleared by hardware after reset or on request, then loaded through a config write port, so retrained weights need no re-synthesis.
- Sits in place of a layer neuron, between the layer input fan-in selector and the next layer's input register.

Parameters:
- IN_BITS, 6, input bits to the neuron (table address width).
- OUT_BITS, 2, output bits per table entry.
- DEPTH, 2**IN_BITS, table entries. Derived; must not be overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr_req  in  1  single-cycle pulse that starts a table clear sweep.
- busy  out  1  high while the clear sweep runs.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  IN_BITS  table write address.
- cfg_data  in  OUT_BITS  table write data.
- cfg_err  out  1  one-cycle pulse when cfg_we arrives while busy; that write is dropped.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  lookup request accepted this cycle.
- in_data  in  IN_BITS  lookup address (neuron input vector).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_BITS  looked-up neuron output.

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous assert, synchronous deassert, both handled externally.
- Reset values: out_valid=0, out_data=0, cfg_err=0, busy=1, state=CLEAR, clear pointer=0. Table contents are not reset by rst_n.
- FSM states are CLEAR and RUN.
- CLEAR:
  - Each cycle writes 0 to table[ptr] and increments ptr.
  - On the cycle ptr==DEPTH-1 the state moves to RUN. The sweep takes exactly DEPTH cycles.
  - busy=1 and in_ready=0 for the whole sweep.
  - clr_req in CLEAR is ignored; the sweep does not restart.
- RUN:
  - busy=0.
  - clr_req=1 moves the state to CLEAR with ptr=0 on the next cycle.
  - A lookup accepted in the same cycle as clr_req completes normally and is not flushed.
- In-flight output on entering CLEAR: an already-valid out_data is held until it is consumed.
- Handshake:
  - in_ready = (state==RUN) && !clr_req && (!out_valid || out_ready).
  - Transfer happens on in_valid && in_ready.
  - Latency is 1 cycle: the input is accepted at edge T, and out_valid/out_data are valid after edge T.
  - Full throughput when out_ready stays high.
  - While out_valid && !out_ready, out_data and out_valid hold stable.
  - out_valid drops after a consuming cycle with no new accept.
- Config writes:
  - Accepted only in RUN; one entry per cycle; the write is synchronous.
  - When a write and a lookup hit the same address in the same cycle, the lookup returns the OLD entry (read-before-write). The new value is visible from the next cycle.
  - cfg_we while busy: the write is dropped and cfg_err=1 for one cycle.
  - cfg_we in the same cycle as clr_req in RUN: the write is performed, then the sweep overwrites it.
- Width rules: no arithmetic on data. The pointer is IN_BITS wide, and its wrap at DEPTH-1 coincides with leaving CLEAR.
- Reset mid-operation: any state returns to CLEAR, ptr=0, out_valid=0. Any in-flight lookup is lost.

Decomposition:
- Shared package lut_neuron_pkg holds:
  - the default IN_BITS/OUT_BITS constants;
  - the FSM state enum (CLEAR, RUN);
  - a function computing DEPTH.
- One sub-module, lut_neuron_table_ram:
  - DEPTH x OUT_BITS distributed RAM;
  - one synchronous write port;
  - one asynchronous read port, registered by the parent.
  - The clear-write and config-write paths are muxed in the parent.

Test Plan:
- Reset then idle, defaults: busy=1 for exactly 64 cycles, in_ready=0 throughout, then busy=0. Afterwards, lookups of addresses 0, 63 and 42 return 2'b00.
- Program and look up: write addr 6'b101010 = 2'b11 and addr 6'b000001 = 2'b10, then look up both back-to-back with out_ready=1. Expect out_data 2'b11 then 2'b10 on consecutive cycles, each 1 cycle after acceptance.
- Backpressure: hold out_ready=0 with out_valid=1 for 5 cycles. out_data stays stable and in_ready=0. Raise out_ready; the next input is accepted the same cycle.
- Same-address collision: write addr 5 = 2'b01 (old 2'b00) while looking up addr 5. Expect result 2'b00; the lookup of addr 5 on the next cycle returns 2'b01.
- Clear and config error:
  - clr_req after programming: busy high for 64 cycles; all entries then read 2'b00.
  - cfg_we during the sweep pulses cfg_err for one cycle and does not alter the table.
- Async reset mid-stream: assert rst_n=0 while out_valid=1. out_valid drops immediately, and the device re-enters CLEAR.
